tensor_burst_controller: RTL and testbench

- Parametrised burst engine that streams whole matrices between the external bus and the tensor core register file.
- Supports any matrix dimension, any number of elements per beat (lanes) and any number of addressable matrices.
- Uses valid/ready handshakes on both data directions and reports completion.
- Sits between the instruction decoder and the register file's multi-element write and read ports.

---
 rtl/tensor_burst_controller_if.sv | 77 +++++++
 rtl/tensor_burst_controller.sv | 137 +++++++++++++
 tb/tb_tensor_burst_controller.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_burst_controller_if.sv
// Bus bundle for tensor_burst_controller: command, write stream, register file ports,
// read stream and status. The slave modport is the controller's view; master is the
// surrounding logic (decoder, producer, register file, consumer).
interface tensor_burst_controller_if #(
  parameter int unsigned BUS_WIDTH    = 8,
  parameter int unsigned MATRIX_DIM   = 3,
  parameter int unsigned LANES        = 2,
  parameter int unsigned NUM_MATRICES = 2
) ();

  localparam int unsigned ELEMS = MATRIX_DIM * MATRIX_DIM;
  localparam int unsigned IW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int unsigned MW    = $clog2(NUM_MATRICES);
  localparam int unsigned DW    = LANES * BUS_WIDTH;

  // Command
  logic          cmd_valid_in;
  logic          cmd_ready_out;
  logic          cmd_write_in;
  logic [MW-1:0] cmd_matrix_in;
  logic          abort_in;

  // Write stream
  logic          wr_valid_in;
  logic          wr_ready_out;
  logic [DW-1:0] wr_data_in;

  // Register file write port
  logic             rf_write_enable_out;
  logic [MW-1:0]    rf_write_matrix_out;
  logic [IW-1:0]    rf_write_index_out;
  logic [LANES-1:0] rf_write_lane_mask_out;
  logic [DW-1:0]    rf_write_data_out;

  // Register file read port
  logic [MW-1:0] rf_read_matrix_out;
  logic [IW-1:0] rf_read_index_out;
  logic [DW-1:0] rf_read_data_in;

  // Read stream
  logic             rd_valid_out;
  logic             rd_ready_in;
  logic [DW-1:0]    rd_data_out;
  logic [LANES-1:0] rd_lane_mask_out;
  logic             rd_last_out;

  // Status
  logic busy_out;
  logic done_out;

  modport slave (
    input  cmd_valid_in, cmd_write_in, cmd_matrix_in, abort_in,
    input  wr_valid_in, wr_data_in,
    input  rf_read_data_in,
    input  rd_ready_in,
    output cmd_ready_out, wr_ready_out,
    output rf_write_enable_out, rf_write_matrix_out, rf_write_index_out,
    output rf_write_lane_mask_out, rf_write_data_out,
    output rf_read_matrix_out, rf_read_index_out,
    output rd_valid_out, rd_data_out, rd_lane_mask_out, rd_last_out,
    output busy_out, done_out
  );

  modport master (
    output cmd_valid_in, cmd_write_in, cmd_matrix_in, abort_in,
    output wr_valid_in, wr_data_in,
    output rf_read_data_in,
    output rd_ready_in,
    input  cmd_ready_out, wr_ready_out,
    input  rf_write_enable_out, rf_write_matrix_out, rf_write_index_out,
    input  rf_write_lane_mask_out, rf_write_data_out,
    input  rf_read_matrix_out, rf_read_index_out,
    input  rd_valid_out, rd_data_out, rd_lane_mask_out, rd_last_out,
    input  busy_out, done_out
  );

endinterface

// File: rtl/tensor_burst_controller.sv
// Burst engine moving whole square matrices between a beat-oriented bus and the
// tensor register file. One command moves one matrix, LANES elements per beat,
// row-major; the last beat may be partial and is qualified by a lane mask.
module tensor_burst_controller #(
  parameter int unsigned BUS_WIDTH    = 8,
  parameter int unsigned MATRIX_DIM   = 3,
  parameter int unsigned LANES        = 2,
  parameter int unsigned NUM_MATRICES = 2
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  tensor_burst_controller_if.slave bus
);

  localparam int unsigned ELEMS = MATRIX_DIM * MATRIX_DIM;
  localparam int unsigned BEATS = (ELEMS + LANES - 1) / LANES;
  localparam int unsigned IW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int unsigned MW    = $clog2(NUM_MATRICES);
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [MW-1:0]    matrix_q, matrix_d;

  logic             last_beat;
  logic [IW-1:0]    base_index;
  logic [LANES-1:0] lane_mask;

  assign last_beat  = (count_q == CW'(BEATS - 1));
  assign base_index = IW'(32'(count_q) * LANES);

  // Lane k of the current beat is live only while its element lies inside the matrix.
  always_comb begin
    lane_mask = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_mask[k] = ((32'(count_q) * LANES + k) < ELEMS);
    end
  end

  // State, beat counter and latched matrix number.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q  <= StIdle;
      count_q  <= '0;
      matrix_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      matrix_q <= matrix_d;
    end
  end

  // Next-state logic and handshake/strobe outputs.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    matrix_d = matrix_q;

    bus.cmd_ready_out          = 1'b0;
    bus.wr_ready_out           = 1'b0;
    bus.rf_write_enable_out    = 1'b0;
    bus.rf_write_lane_mask_out = '0;
    bus.rf_write_data_out      = '0;
    bus.rd_valid_out           = 1'b0;
    bus.rd_data_out            = '0;
    bus.rd_lane_mask_out       = '0;
    bus.rd_last_out            = 1'b0;
    bus.done_out               = 1'b0;

    unique case (state_q)
      StIdle: begin
        // abort_in doubles as a command blocker while idle
        bus.cmd_ready_out = !bus.abort_in;
        if (bus.cmd_valid_in && !bus.abort_in) begin
          matrix_d = bus.cmd_matrix_in;
          count_d  = '0;
          state_d  = bus.cmd_write_in ? StWrite : StRead;
        end
      end

      StWrite: begin
        bus.wr_ready_out           = 1'b1;
        bus.rf_write_lane_mask_out = lane_mask;
        bus.rf_write_data_out      = bus.wr_data_in;
        if (bus.abort_in) begin
          state_d = StIdle;
        end else if (bus.wr_valid_in) begin
          // write lands on the same edge as the handshake
          bus.rf_write_enable_out = 1'b1;
          if (last_beat) begin
            state_d = StDone;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end

      StRead: begin
        bus.rd_valid_out     = 1'b1;
        bus.rd_lane_mask_out = lane_mask;
        bus.rd_last_out      = last_beat;
        for (int unsigned k = 0; k < LANES; k++) begin
          if (lane_mask[k]) begin
            bus.rd_data_out[k*BUS_WIDTH +: BUS_WIDTH] =
              bus.rf_read_data_in[k*BUS_WIDTH +: BUS_WIDTH];
          end
        end
        if (bus.abort_in) begin
          state_d = StIdle;
        end else if (bus.rd_ready_in) begin
          if (last_beat) begin
            state_d = StDone;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end

      StDone: begin
        bus.done_out = !bus.abort_in;
        state_d      = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // Addresses track the registered counter/matrix, so they hold between bursts.
  assign bus.rf_write_matrix_out = matrix_q;
  assign bus.rf_write_index_out  = base_index;
  assign bus.rf_read_matrix_out  = matrix_q;
  assign bus.rf_read_index_out   = base_index;
  assign bus.busy_out            = (state_q != StIdle);

endmodule

// File: tb/tb_tensor_burst_controller.sv
// Self-checking bench for tensor_burst_controller: default configuration against a
// matrix-level reference model, plus short runs of two alternate lane/dimension setups.
module tb_tensor_burst_controller;

  localparam int unsigned BW    = 8;
  localparam int unsigned DIM   = 3;
  localparam int unsigned LN    = 2;
  localparam int unsigned NM    = 2;
  localparam int unsigned ELEMS = DIM * DIM;
  localparam int unsigned BEATS = (ELEMS + LN - 1) / LN;
  localparam int unsigned DW    = LN * BW;

  logic clock_in = 1'b0;
  logic reset_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int total = 0;
  int bad   = 0;

  tensor_burst_controller_if #(.BUS_WIDTH(BW), .MATRIX_DIM(DIM), .LANES(LN),
                               .NUM_MATRICES(NM)) bus ();
  tensor_burst_controller #(.BUS_WIDTH(BW), .MATRIX_DIM(DIM), .LANES(LN),
                            .NUM_MATRICES(NM)) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus.slave)
  );

  // LANES=3, MATRIX_DIM=3 and LANES=4, MATRIX_DIM=2 variants.
  tensor_burst_controller_if #(.BUS_WIDTH(8), .MATRIX_DIM(3), .LANES(3),
                               .NUM_MATRICES(2)) bus3 ();
  tensor_burst_controller #(.BUS_WIDTH(8), .MATRIX_DIM(3), .LANES(3),
                            .NUM_MATRICES(2)) dut3 (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus3.slave)
  );
  tensor_burst_controller_if #(.BUS_WIDTH(8), .MATRIX_DIM(2), .LANES(4),
                               .NUM_MATRICES(2)) bus4 ();
  tensor_burst_controller #(.BUS_WIDTH(8), .MATRIX_DIM(2), .LANES(4),
                            .NUM_MATRICES(2)) dut4 (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus4.slave)
  );

  // Register file environment: masked multi-lane write, combinational read.
  logic [BW-1:0] rf_mem [NM][ELEMS];
  always @(posedge clock_in) begin
    if (bus.rf_write_enable_out) begin
      for (int k = 0; k < int'(LN); k++) begin
        if (bus.rf_write_lane_mask_out[k])
          rf_mem[bus.rf_write_matrix_out][int'(bus.rf_write_index_out) + k] <=
            bus.rf_write_data_out[k*BW +: BW];
      end
    end
  end
  always_comb begin
    bus.rf_read_data_in = '0;
    for (int k = 0; k < int'(LN); k++) begin
      int e;
      e = int'(bus.rf_read_index_out) + k;
      bus.rf_read_data_in[k*BW +: BW] = (e < int'(ELEMS)) ? rf_mem[bus.rf_read_matrix_out][e]
                                                          : 8'hA5;
    end
  end

  // Reference: matrix contents as committed element by element.
  logic [BW-1:0] ref_mat [NM][ELEMS];
  logic [DW-1:0] wdat [BEATS];

  function automatic logic [LN-1:0] exp_mask(input int b);
    logic [LN-1:0] r = '0;
    for (int k = 0; k < int'(LN); k++) r[k] = (b * int'(LN) + k) < int'(ELEMS);
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_beat(input int m, input int b);
    logic [DW-1:0] r = '0;
    for (int k = 0; k < int'(LN); k++) begin
      int e = b * int'(LN) + k;
      if (e < int'(ELEMS)) r[k*BW +: BW] = ref_mat[m][e];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    for (int b = 0; b < int'(BEATS); b++) wdat[b] = DW'($urandom);
  endtask

  // mode: 0 valid always, 1 valid every other cycle, 2 random valid.
  task automatic do_write(input int m, input int mode, input int abort_beat,
                          input int exp_done_cyc);
    int   b   = 0;
    int   cyc = 0;
    logic v;
    bus.cmd_valid_in  = 1'b1;
    bus.cmd_write_in  = 1'b1;
    bus.cmd_matrix_in = m[0];
    @(negedge clock_in);
    check("w_cmd_ready", bus.cmd_ready_out, 1);
    @(posedge clock_in); #1;
    bus.cmd_valid_in = 1'b0;
    while (b < int'(BEATS) && cyc < 60) begin
      cyc++;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      bus.wr_valid_in = v;
      bus.wr_data_in  = wdat[b];
      bus.abort_in    = v && (b == abort_beat);
      @(negedge clock_in);
      check("w_busy", bus.busy_out, 1);
      check("w_ready", bus.wr_ready_out, 1);
      if (bus.abort_in) begin
        check("abort_no_write", bus.rf_write_enable_out, 0);
        @(posedge clock_in); #1;
        bus.abort_in    = 1'b0;
        bus.wr_valid_in = 1'b0;
        #1;
        check("abort_idle", bus.busy_out, 0);
        check("abort_no_done", bus.done_out, 0);
        return;
      end
      check("w_enable", bus.rf_write_enable_out, v);
      if (v) begin
        check("w_index", bus.rf_write_index_out, b * int'(LN));
        check("w_mask", bus.rf_write_lane_mask_out, exp_mask(b));
        check("w_data", bus.rf_write_data_out, wdat[b]);
        check("w_matrix", bus.rf_write_matrix_out, m);
        for (int k = 0; k < int'(LN); k++)
          if (b * int'(LN) + k < int'(ELEMS)) ref_mat[m][b * int'(LN) + k] = wdat[b][k*BW +: BW];
        b++;
      end
      @(posedge clock_in); #1;
    end
    bus.wr_valid_in = 1'b0;
    @(negedge clock_in);
    check("w_done", bus.done_out, 1);
    check("w_done_cmd_ready", bus.cmd_ready_out, 0);
    if (exp_done_cyc > 0) check("w_done_cycle", cyc + 1, exp_done_cyc);
    @(posedge clock_in); #2;
    check("w_done_pulse", bus.done_out, 0);
    check("w_idle", bus.busy_out, 0);
  endtask

  // stall_beat >= 0: stall that beat stall_n cycles; -2: random stalls per beat.
  task automatic do_read(input int m, input int stall_beat, input int stall_n,
                         input int reset_beat);
    bus.cmd_valid_in  = 1'b1;
    bus.cmd_write_in  = 1'b0;
    bus.cmd_matrix_in = m[0];
    @(negedge clock_in);
    check("r_cmd_ready", bus.cmd_ready_out, 1);
    @(posedge clock_in); #1;
    bus.cmd_valid_in = 1'b0;
    for (int b = 0; b < int'(BEATS); b++) begin
      int st;
      st = (stall_beat == -2) ? int'($urandom_range(0, 2)) : (b == stall_beat) ? stall_n : 0;
      for (int s = 0; s <= st; s++) begin
        bus.rd_ready_in = (s == st);
        @(negedge clock_in);
        check("r_valid", bus.rd_valid_out, 1);
        check("r_data", bus.rd_data_out, exp_beat(m, b));
        check("r_mask", bus.rd_lane_mask_out, exp_mask(b));
        check("r_last", bus.rd_last_out, b == int'(BEATS) - 1);
        if (b == reset_beat && s == st) begin
          #2 reset_in = 1'b0;
          #1;
          check("rst_rd_valid", bus.rd_valid_out, 0);
          check("rst_cmd_ready", bus.cmd_ready_out, 1);
          check("rst_busy", bus.busy_out, 0);
          bus.rd_ready_in = 1'b0;
          @(posedge clock_in); #1;
          @(posedge clock_in); #2;
          reset_in = 1'b1;
          #1;
          check("rst_index", bus.rf_read_index_out, 0);
          check("rst_matrix", bus.rf_read_matrix_out, 0);
          return;
        end
        @(posedge clock_in); #1;
      end
    end
    bus.rd_ready_in = 1'b0;
    @(negedge clock_in);
    check("r_done", bus.done_out, 1);
    check("r_valid_done", bus.rd_valid_out, 0);
    @(posedge clock_in); #2;
    check("r_done_pulse", bus.done_out, 0);
    check("r_idle", bus.busy_out, 0);
  endtask

  initial begin
    bus.cmd_valid_in = 0; bus.cmd_write_in = 0; bus.cmd_matrix_in = '0; bus.abort_in = 0;
    bus.wr_valid_in = 0;  bus.wr_data_in = '0;  bus.rd_ready_in = 0;
    bus3.cmd_valid_in = 0; bus3.cmd_write_in = 0; bus3.cmd_matrix_in = '0; bus3.abort_in = 0;
    bus3.wr_valid_in = 0;  bus3.wr_data_in = '0;  bus3.rd_ready_in = 0;
    bus3.rf_read_data_in = '0;
    bus4.cmd_valid_in = 0; bus4.cmd_write_in = 0; bus4.cmd_matrix_in = '0; bus4.abort_in = 0;
    bus4.wr_valid_in = 0;  bus4.wr_data_in = '0;  bus4.rd_ready_in = 0;
    bus4.rf_read_data_in = '0;

    // Reset values
    repeat (2) @(posedge clock_in);
    @(negedge clock_in);
    check("rst_cmd_ready", bus.cmd_ready_out, 1);
    check("rst_busy", bus.busy_out, 0);
    check("rst_wr_ready", bus.wr_ready_out, 0);
    check("rst_rd_valid", bus.rd_valid_out, 0);
    check("rst_we", bus.rf_write_enable_out, 0);
    check("rst_windex", bus.rf_write_index_out, 0);
    check("rst_rd_data", bus.rd_data_out, 0);
    check("rst_done", bus.done_out, 0);
    @(posedge clock_in); #2;
    reset_in = 1'b1;

    // Directed write then stalled read of matrix 1
    wdat[0] = 16'h0201; wdat[1] = 16'h0403; wdat[2] = 16'h0605;
    wdat[3] = 16'h0807; wdat[4] = 16'h0009;
    do_write(1, 0, -1, 6);
    do_read(1, 2, 3, -1);

    // Toggling valid into matrix 0, random-stall readback
    rand_data();
    do_write(0, 1, -1, 0);
    do_read(0, -2, 0, -1);

    // Abort on beat 3; beats 0..2 stay committed; next command one cycle later
    rand_data();
    do_write(0, 0, 3, 0);
    do_read(0, -1, 0, -1);

    // abort_in while idle blocks acceptance
    bus.cmd_valid_in = 1'b1; bus.cmd_write_in = 1'b1; bus.abort_in = 1'b1;
    @(negedge clock_in);
    check("idle_abort_ready", bus.cmd_ready_out, 0);
    @(posedge clock_in); #2;
    check("idle_abort_busy", bus.busy_out, 0);
    bus.cmd_valid_in = 1'b0; bus.abort_in = 1'b0;

    // Random valid write, then reset mid-read, then readback survives
    rand_data();
    do_write(1, 2, -1, 0);
    do_read(1, -1, 0, 2);
    do_read(1, -2, 0, -1);

    // LANES=3, DIM=3: three full beats
    bus3.cmd_valid_in = 1'b1; bus3.cmd_write_in = 1'b1; bus3.cmd_matrix_in = 1'b1;
    @(posedge clock_in); #1;
    bus3.cmd_valid_in = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus3.wr_valid_in = 1'b1;
      bus3.wr_data_in  = 24'($urandom);
      @(negedge clock_in);
      check("l3_we", bus3.rf_write_enable_out, 1);
      check("l3_index", bus3.rf_write_index_out, b * 3);
      check("l3_mask", bus3.rf_write_lane_mask_out, 3'b111);
      @(posedge clock_in); #1;
    end
    bus3.wr_valid_in = 1'b0;
    @(negedge clock_in);
    check("l3_done", bus3.done_out, 1);

    // LANES=4, DIM=2: single beat, done the cycle after
    @(posedge clock_in); #1;
    bus4.cmd_valid_in = 1'b1; bus4.cmd_write_in = 1'b1; bus4.cmd_matrix_in = 1'b0;
    @(posedge clock_in); #1;
    bus4.cmd_valid_in = 1'b0;
    bus4.wr_valid_in  = 1'b1;
    bus4.wr_data_in   = 32'hDEADBEEF;
    @(negedge clock_in);
    check("l4_we", bus4.rf_write_enable_out, 1);
    check("l4_mask", bus4.rf_write_lane_mask_out, 4'hF);
    check("l4_index", bus4.rf_write_index_out, 0);
    @(posedge clock_in); #1;
    bus4.wr_valid_in = 1'b0;
    @(negedge clock_in);
    check("l4_done", bus4.done_out, 1);
    @(posedge clock_in); #2;
    check("l4_idle", bus4.busy_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
